set_assoc_cache: RTL

Parametrised write-back, write-allocate cache between the processor data port and main memory. Supports 1- or 2-way set associativity, configurable set count and block size, and LRU replacement. A request/ready handshake on the processor side and a request/acknowledge block-transfer handshake on the memory side are sequenced by a miss-handling FSM. Includes saturating hit and miss counters for performance monitoring.

---
 rtl/set_assoc_cache.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_cache.sv
// set_assoc_cache
//   Write-back, write-allocate cache with 1- or 2-way set associativity and
//   LRU replacement, sitting between a processor data port and main memory.
//
// Ports
//   CLK, rst            clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   processor request, held stable until cpu_ready
//   cpu_ready, cpu_rdata    one-cycle completion pulse and read data
//   mem_rd_req, mem_wr_req  block refill / write-back requests (never both)
//   mem_addr, mem_wdata     block address and write-back block (word 0 in LSBs)
//   mem_rdata, mem_ack      refill block and request completion
//   hit_cnt, miss_cnt       saturating performance counters
module set_assoc_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int WORDS      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                   CLK,
  input  logic                                   rst,
  input  logic                                   cpu_req,
  input  logic                                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]                  cpu_addr,
  input  logic [DATA_WIDTH-1:0]                  cpu_wdata,
  output logic                                   cpu_ready,
  output logic [DATA_WIDTH-1:0]                  cpu_rdata,
  output logic                                   mem_rd_req,
  output logic                                   mem_wr_req,
  output logic [ADDR_WIDTH-$clog2(WORDS)-1:0]    mem_addr,
  output logic [WORDS*DATA_WIDTH-1:0]            mem_wdata,
  input  logic [WORDS*DATA_WIDTH-1:0]            mem_rdata,
  input  logic                                   mem_ack,
  output logic [CNT_WIDTH-1:0]                   hit_cnt,
  output logic [CNT_WIDTH-1:0]                   miss_cnt
);

  localparam int OFF = $clog2(WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_WIDTH - IDX - OFF;
  localparam int BLK = WORDS * DATA_WIDTH;
  localparam int BA  = ADDR_WIDTH - OFF;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    victim_q, victim_d;
  logic                    refilled_q, refilled_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                    mem_rd_req_q, mem_rd_req_d;
  logic                    mem_wr_req_q, mem_wr_req_d;
  logic [BA-1:0]           mem_addr_q, mem_addr_d;
  logic [BLK-1:0]          mem_wdata_q, mem_wdata_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]         valid_q [WAYS];
  logic [SETS-1:0]         valid_d [WAYS];
  logic [SETS-1:0]         dirty_q [WAYS];
  logic [SETS-1:0]         dirty_d [WAYS];
  logic [SETS-1:0]         lru_q, lru_d;

  // Tag and data storage; contents are only meaningful where valid is set,
  // so they carry no reset.
  logic [TAG-1:0]          tag_ram  [WAYS][SETS];
  logic [BLK-1:0]          data_ram [WAYS][SETS];
  logic                    ram_we;
  logic                    ram_way;
  logic [BLK-1:0]          ram_blk;

  // Fields of the latched request address.
  logic [TAG-1:0]          lk_tag;
  logic [IDX-1:0]          lk_idx;
  logic [OFF-1:0]          lk_off;
  assign lk_tag = addr_q[ADDR_WIDTH-1 -: TAG];
  assign lk_idx = addr_q[OFF +: IDX];
  assign lk_off = addr_q[OFF-1:0];

  logic [WAYS-1:0]         way_match;
  logic                    hit;
  logic                    hit_way;
  logic                    victim_way;
  logic [BLK-1:0]          hit_blk;
  logic [BLK-1:0]          merged_blk;
  logic [DATA_WIDTH-1:0]   hit_word;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
    assign way_match[gi] = valid_q[gi][lk_idx] && (tag_ram[gi][lk_idx] == lk_tag);
  end

  assign hit = |way_match;

  always_comb begin
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w]) hit_way = w[0:0];
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the LRU way.
  always_comb begin
    victim_way = (WAYS > 1) ? lru_q[lk_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][lk_idx]) victim_way = w[0:0];
    end
  end

  assign hit_blk  = data_ram[hit_way][lk_idx];
  assign hit_word = hit_blk[lk_off*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    merged_blk = hit_blk;
    merged_blk[lk_off*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    refilled_d   = refilled_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;
    ram_we       = 1'b0;
    ram_way      = hit_way;
    ram_blk      = merged_blk;

    unique case (state_q)
      IDLE: begin
        // The request is still asserted in the cycle cpu_ready pulses; it
        // belongs to the access just completed, so it is not re-latched.
        if (cpu_req && !cpu_ready_q) begin
          addr_d     = cpu_addr;
          we_d       = cpu_we;
          wdata_d    = cpu_wdata;
          refilled_d = 1'b0;
          state_d    = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          if (we_q) begin
            ram_we                 = 1'b1;
            dirty_d[hit_way][lk_idx] = 1'b1;
          end else begin
            cpu_rdata_d = hit_word;
          end
          cpu_ready_d = 1'b1;
          if (WAYS > 1) lru_d[lk_idx] = ~hit_way;
          // The re-lookup after a refill is the tail of a miss, not a hit.
          if (!refilled_q && !(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
          state_d = IDLE;
        end else begin
          if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
          victim_d = victim_way;
          if (valid_q[victim_way][lk_idx] && dirty_q[victim_way][lk_idx]) begin
            mem_wr_req_d = 1'b1;
            mem_addr_d   = {tag_ram[victim_way][lk_idx], lk_idx};
            mem_wdata_d  = data_ram[victim_way][lk_idx];
            state_d      = WRITEBACK;
          end else begin
            mem_rd_req_d = 1'b1;
            mem_addr_d   = {lk_tag, lk_idx};
            state_d      = REFILL;
          end
        end
      end

      WRITEBACK: begin
        if (mem_ack) begin
          mem_wr_req_d = 1'b0;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = {lk_tag, lk_idx};
          state_d      = REFILL;
        end
      end

      REFILL: begin
        if (mem_ack) begin
          mem_rd_req_d              = 1'b0;
          ram_we                    = 1'b1;
          ram_way                   = victim_q;
          ram_blk                   = mem_rdata;
          valid_d[victim_q][lk_idx] = 1'b1;
          dirty_d[victim_q][lk_idx] = 1'b0;
          refilled_d                = 1'b1;
          state_d                   = LOOKUP;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      victim_q     <= 1'b0;
      refilled_q   <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      victim_q     <= victim_d;
      refilled_q   <= refilled_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= valid_d[w];
        dirty_q[w] <= dirty_d[w];
      end
      lru_q        <= lru_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      data_ram[ram_way][lk_idx] <= ram_blk;
      tag_ram[ram_way][lk_idx]  <= lk_tag;
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule
